// File: rtl/recip_divider_seq.sv
// Exact unsigned a/b (quotient, remainder, div-by-zero, tag) from a ROM-seeded reciprocal; RECIP_DIVIDER_NR_EN adds one Newton-Raphson step.
// Latency 7+k (NR) or 5+k cycles, zero divisor 1 cycle; one op in flight, result held in DONE until out_ready.
module recip_divider_seq #(
    parameter int WIDTH      = 16,
    parameter int TABLE_BITS = 9,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dbz,
    output logic [TAG_W-1:0] out_tag
);
    localparam int T  = TABLE_BITS;
    localparam int YW = T + 2;
    localparam int MW = WIDTH + T + 2;
    localparam int PW = 2 * MW;
`ifdef RECIP_DIVIDER_NR_EN
    localparam int YF = WIDTH + T + 1;
`else
    localparam int YF = T + 1;
`endif
    localparam int SW = $clog2(YF + WIDTH + 1);
    localparam int LW = $clog2(WIDTH);
    localparam int RW = WIDTH + 2;

    // Entry i = round(2^(2T+1) / (2^T + i)): reciprocal of 1.idx with T+1 fraction bits.
    function automatic logic [(2**T)*YW-1:0] build_rom();
        logic [(2**T)*YW-1:0] rom;
        longint num, den;
        rom = '0;
        for (int i = 0; i < 2**T; i++) begin
            num = longint'(1) << (2 * T + 2);
            den = (longint'(1) << T) + longint'(i);
            rom[i*YW +: YW] = YW'((num / den + 1) >> 1);
        end
        return rom;
    endfunction

    localparam logic [(2**T)*YW-1:0] ROM = build_rom();

    function automatic logic [LW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [LW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) n = LW'(WIDTH - 1 - i);
        return n;
    endfunction

    typedef enum logic [3:0] {
        IDLE, NORM, LOOKUP,
`ifdef RECIP_DIVIDER_NR_EN
        REF1, REF2,
`endif
        EST, CHECK, CORR, DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_r, b_r, bn_r, q_r, r_r;
    logic [TAG_W-1:0] tag_r;
    logic [LW-1:0]    s_r;
    logic [YW-1:0]    y0_r;
    logic             dbz_r;
    logic [PW-1:0]    prod;
    logic [MW-1:0]    mul_a, mul_b;
    logic [T-1:0]     idx;
    logic [SW-1:0]    sh;
    logic [PW-1:0]    q_full;
    logic [WIDTH-1:0] q_est;
    logic [RW-1:0]    rem;
    logic             rem_neg, rem_ge;

    assign idx     = T'({bn_r, {T{1'b0}}} >> (WIDTH - 1));
    assign sh      = SW'(YF + WIDTH - 1) - SW'(s_r);
    assign q_full  = prod >> sh;
    assign q_est   = (|q_full[PW-1:WIDTH]) ? '1 : q_full[WIDTH-1:0];
    // True remainder always fits WIDTH+2 signed bits, so the low product bits suffice.
    assign rem     = {2'b00, a_r} - prod[RW-1:0];
    assign rem_neg = rem[RW-1];
    assign rem_ge  = !rem_neg && (rem >= {2'b00, b_r});

`ifdef RECIP_DIVIDER_NR_EN
    logic [MW-1:0] two_minus_e;
    assign two_minus_e = (MW'(1) << (WIDTH + T + 1)) - prod[MW-1:0];
`endif

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
`ifdef RECIP_DIVIDER_NR_EN
            REF1:  begin mul_a = MW'(bn_r); mul_b = MW'(y0_r);   end
            REF2:  begin mul_a = MW'(y0_r); mul_b = two_minus_e; end
            EST:   begin mul_a = MW'(a_r);  mul_b = prod[T +: MW]; end
`else
            EST:   begin mul_a = MW'(a_r);  mul_b = MW'(y0_r);   end
`endif
            CHECK: begin mul_a = MW'(q_est); mul_b = MW'(b_r);   end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (in_valid) state_nx = NORM;
            // Zero divisor leaves from NORM so its result shows one cycle after accept.
            NORM:   state_nx = (b_r == '0) ? DONE : LOOKUP;
`ifdef RECIP_DIVIDER_NR_EN
            LOOKUP: state_nx = REF1;
            REF1:   state_nx = REF2;
            REF2:   state_nx = EST;
`else
            LOOKUP: state_nx = EST;
`endif
            EST:    state_nx = CHECK;
            CHECK:  state_nx = CORR;
            CORR:   if (!rem_neg && !rem_ge) state_nx = DONE;
            DONE:   if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            bn_r  <= '0;
            s_r   <= '0;
            y0_r  <= '0;
            prod  <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
            tag_r <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= in_a;
                    b_r   <= in_b;
                    tag_r <= in_tag;
                    dbz_r <= 1'b0;
                end
                NORM: begin
                    s_r  <= lzc(b_r);
                    bn_r <= b_r << lzc(b_r);
                    if (b_r == '0) begin
                        q_r   <= '1;
                        r_r   <= a_r;
                        dbz_r <= 1'b1;
                    end
                end
                LOOKUP: y0_r <= ROM[idx*YW +: YW];
`ifdef RECIP_DIVIDER_NR_EN
                REF1, REF2,
`endif
                EST: prod <= PW'(mul_a) * PW'(mul_b);
                CHECK: begin
                    prod <= PW'(mul_a) * PW'(mul_b);
                    q_r  <= q_est;
                end
                // prod tracks q*b so the remainder stays a - prod while stepping.
                CORR: begin
                    if (rem_neg) begin
                        q_r  <= q_r - WIDTH'(1);
                        prod <= prod - PW'(b_r);
                    end else if (rem_ge) begin
                        q_r  <= q_r + WIDTH'(1);
                        prod <= prod + PW'(b_r);
                    end else begin
                        r_r  <= rem[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_q     = q_r;
    assign out_r     = r_r;
    assign out_dbz   = dbz_r;
    assign out_tag   = tag_r;
endmodule

// File: tb/tb_recip_divider_seq.sv
// Bench for recip_divider_seq: directed cases plus random operands with random output stalls, against plain a/b and a%b.
module tb_recip_divider_seq;
    localparam int W  = 16;
    localparam int TB = 9;
    localparam int TW = 4;
`ifdef RECIP_DIVIDER_NR_EN
    localparam int BASE_LAT = 7;
    localparam int K_MAX    = 2;
`else
    localparam int BASE_LAT = 5;
    localparam int K_MAX    = (1 << (W - TB + 1)) + 2;
`endif
    localparam int TIMEOUT  = 600;
    localparam int N_RAND   = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_q, out_r;
    logic          out_dbz;
    logic [TW-1:0] out_tag;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    recip_divider_seq #(.WIDTH(W), .TABLE_BITS(TB), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .out_tag(out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Starts #1 after a clock edge with the DUT idle; ends #1 after the output handshake edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input int hold);
        logic [W-1:0] exp_q, exp_r;
        logic         exp_dbz;
        int           lat;
        if (b == '0) begin
            exp_q = '1; exp_r = a; exp_dbz = 1'b1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dbz = 1'b0;
        end
        check("in_ready_idle", in_ready, 1);
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        // Keep offering junk while busy; it must be ignored.
        in_a = W'($urandom); in_b = W'($urandom); in_tag = TW'($urandom);
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", out_valid, 1);
        if (exp_dbz)
            check("latency_dbz", lat, 1);
        else
            check("latency_in_range", (lat >= BASE_LAT) && (lat <= BASE_LAT + K_MAX), 1);
        for (int i = 0; i <= hold; i++) begin
            check("q", out_q, exp_q);
            check("r", out_r, exp_r);
            check("dbz", out_dbz, exp_dbz);
            check("tag", out_tag, tag);
            if (i > 0) begin
                check("valid_held", out_valid, 1);
                check("ready_low_held", in_ready, 0);
            end
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int nb;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", out_q, 0);
        check("rst_r", out_r, 0);
        check("rst_dbz", out_dbz, 0);
        check("rst_tag", out_tag, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        run_op(16'd1000, 16'd7, 4'd3, 0);
        run_op(16'd65535, 16'd1, 4'd1, 0);
        run_op(16'd65535, 16'd65535, 4'd2, 1);
        run_op(16'd12345, 16'd0, 4'd9, 0);
        run_op(16'd5, 16'd65535, 4'd7, 10);
        run_op(16'd0, 16'd3, 4'd4, 0);
        run_op(16'd32768, 16'd128, 4'd6, 0);

        // Abort a 40000/3 while it sits in CHECK.
        in_a = 16'd40000; in_b = 16'd3; in_tag = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (BASE_LAT - 2) @(posedge clk);
        #1; reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_q", out_q, 0);
        check("abort_r", out_r, 0);
        check("abort_tag", out_tag, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        run_op(16'd9, 16'd2, 4'd8, 0);

        for (int n = 0; n < N_RAND && n_fail < 20; n++) begin
            nb = $urandom_range(0, W);
            rb = W'($urandom) & W'((64'd1 << nb) - 64'd1);
            ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
            run_op(ra, rb, TW'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
